// File: rtl/usbf_utmi_rx_decoder_if.sv
// UTMI receive stream plus the decoded packet events it produces.
// Latency: none (signal bundle only).
// Backpressure: none; UTMI receive is a push stream and the decoder outputs are strobes.
//
// master : upstream/bench side; drives the UTMI receive signals, observes the decode.
// slave  : the decoder; consumes the UTMI receive signals, drives the decode outputs.
interface usbf_utmi_rx_decoder_if;
    // UTMI receive side
    logic [7:0]  utmi_data_in_i;
    logic        utmi_rxvalid_i;
    logic        utmi_rxactive_i;
    logic        utmi_rxerror_i;
    // decoded packet side
    logic [3:0]  rx_pid_o;
    logic        rx_token_valid_o;
    logic [6:0]  rx_token_addr_o;
    logic [3:0]  rx_token_ep_o;
    logic [10:0] rx_frame_o;
    logic [7:0]  rx_data_o;
    logic        rx_data_valid_o;
    logic        rx_data_start_o;
    logic        rx_done_o;
    logic        rx_crc_err_o;
    logic        rx_err_o;

    modport master (
        output utmi_data_in_i, utmi_rxvalid_i, utmi_rxactive_i, utmi_rxerror_i,
        input  rx_pid_o, rx_token_valid_o, rx_token_addr_o, rx_token_ep_o, rx_frame_o,
               rx_data_o, rx_data_valid_o, rx_data_start_o, rx_done_o, rx_crc_err_o, rx_err_o
    );

    modport slave (
        input  utmi_data_in_i, utmi_rxvalid_i, utmi_rxactive_i, utmi_rxerror_i,
        output rx_pid_o, rx_token_valid_o, rx_token_addr_o, rx_token_ep_o, rx_frame_o,
               rx_data_o, rx_data_valid_o, rx_data_start_o, rx_done_o, rx_crc_err_o, rx_err_o
    );
endinterface

// File: rtl/usbf_utmi_rx_decoder.sv
// USB receive packet decoder: PID check, token/CRC5, data/CRC16 strip+check, handshakes.
// Latency: payload byte n emitted the cycle after byte n+2 arrives; end-of-packet events 1 cycle after rxactive falls.
// Backpressure: none; the UTMI stream cannot be stalled, so every output is a single-cycle strobe.
//
// Ports:
//   ulpi_clk60_i  60 MHz PHY clock
//   ulpi_rstn_i   asynchronous active-low reset
//   utmi          receive stream in, decoded PID/token/frame/payload/done/error strobes out
module usbf_utmi_rx_decoder #(
    parameter int MAX_PKT_BYTES = 1024
) (
    input  logic                    ulpi_clk60_i,
    input  logic                    ulpi_rstn_i,
    usbf_utmi_rx_decoder_if.slave   utmi
);

    // Byte counter must reach MAX_PKT_BYTES + 2 (payload plus CRC) and still compare.
    localparam int CW = $clog2(MAX_PKT_BYTES + 3) + 1;
    localparam logic [CW-1:0] CNT_BABBLE = CW'(MAX_PKT_BYTES + 2);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PID      = 3'd1;
    localparam logic [2:0] ST_TOKEN    = 3'd2;
    localparam logic [2:0] ST_DATA     = 3'd3;
    localparam logic [2:0] ST_WAIT_END = 3'd4;

    localparam logic [4:0]  CRC5_RESIDUAL  = 5'b01100;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    // Serial CRC update, data LSB first as on the wire.
    function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] d);
        logic [4:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = {r[3:0], 1'b0} ^ ((d[i] ^ r[4]) ? 5'h05 : 5'h00);
        end
        return r;
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = {r[14:0], 1'b0} ^ ((d[i] ^ r[15]) ? 16'h8005 : 16'h0000);
        end
        return r;
    endfunction

    logic [2:0]     state_q;
    logic           first_q;        // high only on the first cycle after reset release
    logic [3:0]     pid_q;
    logic [10:0]    tok_sr_q;       // token payload bits; the CRC5 bits are only checked via the residual
    logic [1:0]     tok_cnt_q;      // saturates at 3 so "too many bytes" is still visible
    logic [4:0]     crc5_q;
    logic [15:0]    crc16_q;
    logic [CW-1:0]  cnt_q;          // bytes received after a DATAx PID
    logic [7:0]     dly0_q;         // most recent byte
    logic [7:0]     dly1_q;         // byte before that; emitted once a third byte proves it is payload
    logic           pend_done_q;    // WAIT_END owes a done strobe at end of packet
    logic           pend_crc_err_q;

    logic           token_valid_q;
    logic [6:0]     token_addr_q;
    logic [3:0]     token_ep_q;
    logic [10:0]    frame_q;
    logic [7:0]     data_q;
    logic           data_valid_q;
    logic           data_start_q;
    logic           done_q;
    logic           crc_err_q;
    logic           err_q;

    logic           rxactive;
    logic           rxerror;
    logic           rxvalid;
    logic [7:0]     rx_byte;

    assign rxactive = utmi.utmi_rxactive_i;
    assign rxerror  = utmi.utmi_rxerror_i;
    assign rxvalid  = utmi.utmi_rxvalid_i & utmi.utmi_rxactive_i;
    assign rx_byte  = utmi.utmi_data_in_i;

    always_ff @(posedge ulpi_clk60_i or negedge ulpi_rstn_i) begin
        if (!ulpi_rstn_i) begin
            state_q        <= ST_IDLE;
            first_q        <= 1'b1;
            pid_q          <= 4'h0;
            tok_sr_q       <= 11'h000;
            tok_cnt_q      <= 2'd0;
            crc5_q         <= 5'h00;
            crc16_q        <= 16'h0000;
            cnt_q          <= '0;
            dly0_q         <= 8'h00;
            dly1_q         <= 8'h00;
            pend_done_q    <= 1'b0;
            pend_crc_err_q <= 1'b0;
            token_valid_q  <= 1'b0;
            token_addr_q   <= 7'h00;
            token_ep_q     <= 4'h0;
            frame_q        <= 11'h000;
            data_q         <= 8'h00;
            data_valid_q   <= 1'b0;
            data_start_q   <= 1'b0;
            done_q         <= 1'b0;
            crc_err_q      <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            first_q       <= 1'b0;
            token_valid_q <= 1'b0;
            data_valid_q  <= 1'b0;
            data_start_q  <= 1'b0;
            done_q        <= 1'b0;
            crc_err_q     <= 1'b0;
            err_q         <= 1'b0;

            // rxactive low is checked first in every busy state: a byte
            // coincident with the fall is dropped by the rxvalid qualifier.
            case (state_q)
                ST_IDLE: begin
                    pend_done_q <= 1'b0;
                    if (rxactive) begin
                        // Reset released mid-packet: the rest of that packet is junk.
                        state_q <= first_q ? ST_WAIT_END : ST_PID;
                    end
                end

                ST_PID: begin
                    if (!rxactive) begin
                        err_q   <= 1'b1;    // packet ended with no PID
                        state_q <= ST_IDLE;
                    end else if (rxerror) begin
                        err_q   <= 1'b1;
                        state_q <= ST_WAIT_END;
                    end else if (rxvalid) begin
                        pid_q <= rx_byte[3:0];
                        if (rx_byte[7:4] != ~rx_byte[3:0]) begin
                            err_q   <= 1'b1;
                            state_q <= ST_WAIT_END;
                        end else begin
                            case (rx_byte[3:0])
                                4'h1, 4'h9, 4'hD, 4'h5: begin   // OUT, IN, SETUP, SOF
                                    tok_cnt_q <= 2'd0;
                                    tok_sr_q  <= 11'h000;
                                    crc5_q    <= 5'h1F;
                                    state_q   <= ST_TOKEN;
                                end
                                4'h3, 4'hB, 4'h7, 4'hF: begin   // DATA0, DATA1, DATA2, MDATA
                                    data_start_q <= 1'b1;
                                    crc16_q      <= 16'hFFFF;
                                    cnt_q        <= '0;
                                    state_q      <= ST_DATA;
                                end
                                4'h2, 4'hA, 4'hE, 4'h6: begin   // ACK, NAK, STALL, NYET
                                    pend_done_q    <= 1'b1;
                                    pend_crc_err_q <= 1'b0;
                                    state_q        <= ST_WAIT_END;
                                end
                                default: begin                  // PRE/SPLIT/PING/reserved
                                    err_q   <= 1'b1;
                                    state_q <= ST_WAIT_END;
                                end
                            endcase
                        end
                    end
                end

                ST_TOKEN: begin
                    if (!rxactive) begin
                        state_q <= ST_IDLE;
                        if (tok_cnt_q == 2'd2 && crc5_q == CRC5_RESIDUAL) begin
                            token_valid_q <= 1'b1;
                            if (pid_q == 4'h5) begin
                                frame_q <= tok_sr_q;
                            end else begin
                                token_addr_q <= tok_sr_q[6:0];
                                token_ep_q   <= tok_sr_q[10:7];
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (rxerror) begin
                        err_q   <= 1'b1;
                        state_q <= ST_WAIT_END;
                    end else if (rxvalid) begin
                        crc5_q <= crc5_byte(crc5_q, rx_byte);
                        if (tok_cnt_q == 2'd0) begin
                            tok_sr_q[7:0] <= rx_byte;
                        end else if (tok_cnt_q == 2'd1) begin
                            tok_sr_q[10:8] <= rx_byte[2:0];
                        end
                        if (tok_cnt_q != 2'd3) begin
                            tok_cnt_q <= tok_cnt_q + 2'd1;
                        end
                    end
                end

                ST_DATA: begin
                    if (!rxactive) begin
                        done_q    <= 1'b1;
                        crc_err_q <= (crc16_q != CRC16_RESIDUAL) || (cnt_q < CW'(2));
                        err_q     <= (cnt_q < CW'(2));
                        state_q   <= ST_IDLE;
                    end else if (rxerror) begin
                        err_q          <= 1'b1;
                        pend_done_q    <= 1'b1;
                        pend_crc_err_q <= 1'b1;
                        state_q        <= ST_WAIT_END;
                    end else if (rxvalid) begin
                        if (cnt_q == CNT_BABBLE) begin
                            // Payload would exceed MAX_PKT_BYTES: stop emitting.
                            err_q   <= 1'b1;
                            state_q <= ST_WAIT_END;
                        end else begin
                            crc16_q <= crc16_byte(crc16_q, rx_byte);
                            dly0_q  <= rx_byte;
                            dly1_q  <= dly0_q;
                            cnt_q   <= cnt_q + CW'(1);
                            if (cnt_q >= CW'(2)) begin
                                data_q       <= dly1_q;
                                data_valid_q <= 1'b1;
                            end
                        end
                    end
                end

                ST_WAIT_END: begin
                    if (!rxactive) begin
                        if (pend_done_q) begin
                            done_q    <= 1'b1;
                            crc_err_q <= pend_crc_err_q;
                        end
                        pend_done_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign utmi.rx_pid_o         = pid_q;
    assign utmi.rx_token_valid_o = token_valid_q;
    assign utmi.rx_token_addr_o  = token_addr_q;
    assign utmi.rx_token_ep_o    = token_ep_q;
    assign utmi.rx_frame_o       = frame_q;
    assign utmi.rx_data_o        = data_q;
    assign utmi.rx_data_valid_o  = data_valid_q;
    assign utmi.rx_data_start_o  = data_start_q;
    assign utmi.rx_done_o        = done_q;
    assign utmi.rx_crc_err_o     = crc_err_q;
    assign utmi.rx_err_o         = err_q;

endmodule

// File: tb/tb_usbf_utmi_rx_decoder.sv
// Bench for usbf_utmi_rx_decoder: directed packets then randomized packets against a packet-level model.
// Latency: checks are taken a few cycles after each packet ends.
// Backpressure: none; the bench drives the UTMI stream open-loop.
module tb_usbf_utmi_rx_decoder;

    localparam int MAXB = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    usbf_utmi_rx_decoder_if bus ();

    usbf_utmi_rx_decoder #(.MAX_PKT_BYTES(MAXB)) dut (
        .ulpi_clk60_i (clk),
        .ulpi_rstn_i  (rstn),
        .utmi         (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // observed event counts
    int obs_done = 0, obs_crcerr = 0, obs_err = 0, obs_tok = 0, obs_start = 0;
    logic [7:0] obs_data[$];
    // expected event counts and held outputs
    int exp_done = 0, exp_crcerr = 0, exp_err = 0, exp_tok = 0, exp_start = 0;
    logic [7:0] exp_data[$];
    logic [3:0]  exp_pid   = 4'h0;
    logic [6:0]  exp_addr  = 7'h00;
    logic [3:0]  exp_ep    = 4'h0;
    logic [10:0] exp_frame = 11'h000;

    logic [7:0] pkt[$];
    logic [7:0] pay[$];

    always @(posedge clk) begin
        #1;
        if (bus.rx_done_o) begin
            obs_done++;
            if (bus.rx_crc_err_o) obs_crcerr++;
        end
        if (bus.rx_err_o)         obs_err++;
        if (bus.rx_token_valid_o) obs_tok++;
        if (bus.rx_data_start_o)  obs_start++;
        if (bus.rx_data_valid_o)  obs_data.push_back(bus.rx_data_o);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // CRC fields as transmitted: running CRC complemented, MSB sent first (LSB of field).
    function automatic logic [4:0] crc5_field(input logic [10:0] d);
        logic [4:0] c;
        logic [4:0] r;
        c = 5'h1F;
        for (int i = 0; i < 11; i++)
            c = {c[3:0], 1'b0} ^ ((d[i] ^ c[4]) ? 5'h05 : 5'h00);
        for (int i = 0; i < 5; i++) r[i] = ~c[4-i];
        return r;
    endfunction

    function automatic logic [15:0] crc16_field_of_pay();
        logic [15:0] c;
        logic [15:0] r;
        c = 16'hFFFF;
        foreach (pay[k])
            for (int i = 0; i < 8; i++)
                c = {c[14:0], 1'b0} ^ ((pay[k][i] ^ c[15]) ? 16'h8005 : 16'h0000);
        for (int i = 0; i < 16; i++) r[i] = ~c[15-i];
        return r;
    endfunction

    function automatic logic [7:0] pid_byte(input logic [3:0] p);
        return {~p, p};
    endfunction

    task automatic build_token(input logic [3:0] p, input logic [10:0] d);
        logic [15:0] f;
        f = {crc5_field(d), d};
        pkt = {};
        pkt.push_back(pid_byte(p));
        pkt.push_back(f[7:0]);
        pkt.push_back(f[15:8]);
    endtask

    task automatic build_data(input logic [3:0] p);
        logic [15:0] f;
        f = crc16_field_of_pay();
        pkt = {};
        pkt.push_back(pid_byte(p));
        foreach (pay[k]) pkt.push_back(pay[k]);
        pkt.push_back(f[7:0]);
        pkt.push_back(f[15:8]);
    endtask

    // Packet-level reference: what the decoder should report for pkt,
    // with rxerror raised on byte rxerr_at (-1 for none).
    task automatic model(input int rxerr_at);
        int n, pn;
        logic [7:0] p;
        logic [15:0] f;
        n = pkt.size();
        if (n == 0) return;
        if (rxerr_at == 0) begin exp_err++; return; end
        p = pkt[0];
        exp_pid = p[3:0];
        if (p[7:4] != ~p[3:0]) begin exp_err++; return; end
        case (p[3:0])
            4'h1, 4'h9, 4'hD, 4'h5: begin
                if (rxerr_at > 0) exp_err++;
                else if (n == 3 && crc5_field({pkt[2][2:0], pkt[1]}) == pkt[2][7:3]) begin
                    exp_tok++;
                    if (p[3:0] == 4'h5) exp_frame = {pkt[2][2:0], pkt[1]};
                    else begin
                        exp_addr = pkt[1][6:0];
                        exp_ep   = {pkt[2][2:0], pkt[1][7]};
                    end
                end else exp_err++;
            end
            4'h3, 4'hB, 4'h7, 4'hF: begin
                exp_start++;
                pn = (rxerr_at > 0) ? rxerr_at - 1 : n - 1;
                if (pn >= MAXB + 3) begin
                    exp_err++;
                    for (int i = 0; i < MAXB; i++) exp_data.push_back(pkt[1+i]);
                end else if (rxerr_at > 0) begin
                    exp_err++; exp_done++; exp_crcerr++;
                    for (int i = 0; i < pn - 2; i++) exp_data.push_back(pkt[1+i]);
                end else begin
                    exp_done++;
                    for (int i = 0; i < pn - 2; i++) exp_data.push_back(pkt[1+i]);
                    if (pn < 2) begin
                        exp_err++; exp_crcerr++;
                    end else begin
                        pay = {};
                        for (int i = 0; i < pn - 2; i++) pay.push_back(pkt[1+i]);
                        f = crc16_field_of_pay();
                        if ({pkt[n-1], pkt[n-2]} != f) exp_crcerr++;
                    end
                end
            end
            4'h2, 4'hA, 4'hE, 4'h6: exp_done++;
            default: exp_err++;
        endcase
    endtask

    task automatic send(input int gap_mode, input int rxerr_at, input int post);
        @(negedge clk);
        bus.utmi_rxactive_i = 1'b1;
        foreach (pkt[i]) begin
            int g;
            g = (gap_mode == 1 && i > 0) ? 1 : (gap_mode == 2 ? int'($urandom_range(0, 2)) : 0);
            repeat (g) begin
                @(negedge clk);
                bus.utmi_rxvalid_i = 1'b0;
                bus.utmi_rxerror_i = 1'b0;
            end
            @(negedge clk);
            bus.utmi_data_in_i = pkt[i];
            bus.utmi_rxvalid_i = 1'b1;
            bus.utmi_rxerror_i = (i == rxerr_at);
        end
        @(negedge clk);
        bus.utmi_rxvalid_i  = 1'b0;
        bus.utmi_rxerror_i  = 1'b0;
        bus.utmi_rxactive_i = 1'b0;
        repeat (post) @(negedge clk);
    endtask

    task automatic checkpoint(input string tag);
        int m;
        repeat (3) @(negedge clk);
        check({tag, ".done"},   obs_done,   exp_done);
        check({tag, ".crcerr"}, obs_crcerr, exp_crcerr);
        check({tag, ".err"},    obs_err,    exp_err);
        check({tag, ".tok"},    obs_tok,    exp_tok);
        check({tag, ".start"},  obs_start,  exp_start);
        check({tag, ".pid"},    32'(bus.rx_pid_o),        32'(exp_pid));
        check({tag, ".addr"},   32'(bus.rx_token_addr_o), 32'(exp_addr));
        check({tag, ".ep"},     32'(bus.rx_token_ep_o),   32'(exp_ep));
        check({tag, ".frame"},  32'(bus.rx_frame_o),      32'(exp_frame));
        check({tag, ".nbytes"}, obs_data.size(), exp_data.size());
        m = (obs_data.size() < exp_data.size()) ? obs_data.size() : exp_data.size();
        for (int i = 0; i < m; i++)
            check($sformatf("%s.byte%0d", tag, i), 32'(obs_data[i]), 32'(exp_data[i]));
        obs_data = {};
        exp_data = {};
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".pid"},     32'(bus.rx_pid_o),         0);
        check({tag, ".tokv"},    32'(bus.rx_token_valid_o), 0);
        check({tag, ".addr"},    32'(bus.rx_token_addr_o),  0);
        check({tag, ".ep"},      32'(bus.rx_token_ep_o),    0);
        check({tag, ".frame"},   32'(bus.rx_frame_o),       0);
        check({tag, ".data"},    32'(bus.rx_data_o),        0);
        check({tag, ".dvalid"},  32'(bus.rx_data_valid_o),  0);
        check({tag, ".dstart"},  32'(bus.rx_data_start_o),  0);
        check({tag, ".done"},    32'(bus.rx_done_o),        0);
        check({tag, ".crcerr"},  32'(bus.rx_crc_err_o),     0);
        check({tag, ".err"},     32'(bus.rx_err_o),         0);
    endtask

    initial begin
        int kind, rerr, gm;
        logic [7:0] b;
        logic [3:0] pn;
        logic [3:0] toks[3];
        logic [3:0] dpids[4];
        logic [3:0] hss[4];
        logic [3:0] others[4];
        toks   = '{4'h1, 4'h9, 4'hD};
        dpids  = '{4'h3, 4'hB, 4'h7, 4'hF};
        hss    = '{4'h2, 4'hA, 4'hE, 4'h6};
        others = '{4'hC, 4'h4, 4'h8, 4'h0};

        bus.utmi_data_in_i  = 8'h00;
        bus.utmi_rxvalid_i  = 1'b0;
        bus.utmi_rxactive_i = 1'b0;
        bus.utmi_rxerror_i  = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // ACK handshake
        pkt = {8'hD2};
        model(-1); send(0, -1, 2); checkpoint("ack");

        // DATA0 zero-length, good then corrupted CRC
        pkt = {8'hC3, 8'h00, 8'h00};
        model(-1); send(0, -1, 2); checkpoint("zlp");
        pkt = {8'hC3, 8'h00, 8'h01};
        model(-1); send(0, -1, 2); checkpoint("zlp_bad");

        // SETUP addr 5 ep 1, then one CRC bit flipped (outputs must hold)
        build_token(4'hD, {4'h1, 7'h05});
        model(-1); send(0, -1, 2); checkpoint("setup");
        check("setup.addr5", 32'(bus.rx_token_addr_o), 32'h05);
        check("setup.ep1",   32'(bus.rx_token_ep_o),   32'h1);
        build_token(4'hD, {4'h1, 7'h05});
        pkt[2] = pkt[2] ^ 8'h20;
        model(-1); send(0, -1, 2); checkpoint("setup_bad");

        // DATA1 4 bytes, rxvalid every other cycle
        pay = {8'h01, 8'h02, 8'h03, 8'h04};
        build_data(4'hB);
        model(-1); send(1, -1, 2); checkpoint("data1_gap");

        // bad PID, trailing bytes ignored
        pkt = {8'hD3, 8'h12, 8'h34, 8'h56};
        model(-1); send(0, -1, 2); checkpoint("badpid");

        // DATA0 with rxerror on 3rd byte, ACK back-to-back
        pay = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        build_data(4'h3);
        model(2); send(0, 2, 0);
        pkt = {8'hD2};
        model(-1); send(0, -1, 2); checkpoint("rxerr_b2b");

        // SOF frame number
        build_token(4'h5, 11'h5A7);
        model(-1); send(0, -1, 2); checkpoint("sof");

        // payload exactly at the limit, then one over
        pay = {};
        for (int i = 0; i < MAXB; i++) pay.push_back(8'(i * 7 + 1));
        build_data(4'h7);
        model(-1); send(0, -1, 2); checkpoint("max_len");
        pay.push_back(8'hEE);
        build_data(4'h7);
        model(-1); send(0, -1, 2); checkpoint("babble");

        // truncated data packet and over-long token
        pkt = {8'h4B, 8'h00};
        model(-1); send(0, -1, 2); checkpoint("data_short");
        build_token(4'h9, {4'h3, 7'h21});
        pkt.push_back(8'h00);
        model(-1); send(0, -1, 2); checkpoint("tok_long");

        // asynchronous reset in the middle of a DATA0 packet
        pay = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        build_data(4'h3);
        exp_start++;
        @(negedge clk); bus.utmi_rxactive_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); bus.utmi_data_in_i = pkt[i]; bus.utmi_rxvalid_i = 1'b1;
        end
        @(negedge clk); bus.utmi_rxvalid_i = 1'b0;
        #2 rstn = 1'b0;
        #1 check_reset_outputs("midrst");
        exp_pid = 4'h0; exp_addr = 7'h00; exp_ep = 4'h0; exp_frame = 11'h000;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int i = 3; i < pkt.size(); i++) begin
            @(negedge clk); bus.utmi_data_in_i = pkt[i]; bus.utmi_rxvalid_i = 1'b1;
        end
        @(negedge clk); bus.utmi_rxvalid_i = 1'b0; bus.utmi_rxactive_i = 1'b0;
        checkpoint("midrst_tail");

        // randomized packets
        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 5));
            case (kind)
                0, 1: begin
                    pay = {};
                    repeat ($urandom_range(0, MAXB + 2)) pay.push_back(8'($urandom));
                    build_data(dpids[$urandom_range(0, 3)]);
                end
                2: build_token(toks[$urandom_range(0, 2)], 11'($urandom));
                3: build_token(4'h5, 11'($urandom));
                4: pkt = {pid_byte(hss[$urandom_range(0, 3)])};
                default: begin
                    if ($urandom_range(0, 1) == 0) begin
                        b = 8'($urandom);
                        if (b[7:4] == ~b[3:0]) b[4] = ~b[4];
                    end else begin
                        pn = others[$urandom_range(0, 3)];
                        b = pid_byte(pn);
                    end
                    pkt = {b};
                    repeat ($urandom_range(0, 3)) pkt.push_back(8'($urandom));
                end
            endcase
            if (pkt.size() > 1 && $urandom_range(0, 3) == 0) begin
                int k;
                k = int'($urandom_range(1, pkt.size() - 1));
                pkt[k] = pkt[k] ^ (8'h01 << $urandom_range(0, 7));
            end
            rerr = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, pkt.size() - 1)) : -1;
            gm = int'($urandom_range(0, 2));
            model(rerr);
            send(gm, rerr, int'($urandom_range(0, 2)));
            checkpoint($sformatf("rnd%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
